pwm_breath_multi: RTL and testbench
===================================

PWM_BREATH_MULTI -- requirements
Module: pwm_breath_multi

Interface
REQ-001 SHALL have parameter CH, default 4: number of independent breathing channels, 1..16.
REQ-002 SHALL have parameter PWM_PERIOD, default 500_000: PWM period in clk cycles, which is 10 ms at 50 MHz.
REQ-003 SHALL have parameter PWM_W, default 19: width of the PWM counter and of the duty registers, with 2^PWM_W > PWM_PERIOD.
REQ-004 SHALL have parameter STEPS, default 20: brightness levels per half-breath, with PWM_PERIOD divisible by STEPS.
REQ-005 SHALL have parameter STEP_CYCLES, default 15: PWM periods per level step, >= 1.
REQ-006 SHALL have port clk, input, 1 bit: system clock.
REQ-007 SHALL have port rst_n, input, 1 bit: reset; asynchronous, active-low.
REQ-008 SHALL have port en, input, CH bits: per-channel enable, where en[i] high means channel i breathes.
REQ-009 SHALL have port led, output, CH bits: per-channel LED drive, active-low, where 0 means on.
REQ-010 SHALL have port breath_done, output, CH bits: per-channel one-clk pulse at the end of each full breath.

Function
REQ-011 cnt_pwm SHALL count 0..PWM_PERIOD-1 every clk and wrap to 0. A pwm_wrap event occurs when cnt_pwm == PWM_PERIOD-1.
REQ-012 cnt_step SHALL count pwm_wrap events 0..STEP_CYCLES-1. A tick occurs when pwm_wrap is asserted and cnt_step == STEP_CYCLES-1.
REQ-013 cnt_pwm and cnt_step SHALL run freely, independent of en. All channels SHALL share the same tick.
REQ-014 Each channel SHALL have a 3-state FSM (IDLE, RISE, FALL) and a level register lvl in 0..STEPS, sized to hold STEPS.
REQ-015 IDLE: lvl = 0. The FSM SHALL go to RISE on the clk where en[i] is sampled high. lvl stays 0 until the first tick.
REQ-016 RISE: on tick, lvl SHALL increment. When lvl reaches STEPS, the state SHALL become FALL in the same update.
REQ-017 FALL: on tick, lvl SHALL decrement. When lvl reaches 0, the state SHALL become RISE and breath_done[i] SHALL pulse for exactly 1 clk.
REQ-018 If en[i] is low in any state, the FSM SHALL go to IDLE on the next clk with lvl = 0. This takes priority over a simultaneous tick.
REQ-019 duty_q[i] SHALL be loaded only on pwm_wrap, from the level value being written that same clk, so a new level appears in the very next PWM period. This keeps updates glitch-free.
REQ-020 Linear duty SHALL be lvl * (PWM_PERIOD/STEPS), where PWM_PERIOD/STEPS is a compile-time constant.
REQ-021 led[i] SHALL be registered: led[i] <= ~(en[i] && cnt_pwm < duty_q[i]). This gives 1-clk latency.
REQ-022 At lvl 0 the LED SHALL be fully off; at lvl STEPS it SHALL be fully on for the whole period.
REQ-023 A channel whose en is deasserted SHALL drive led[i] = 1 from the clk after en is sampled low. Its duty_q SHALL clear at the next pwm_wrap.

Reset
REQ-024 On rst_n low, cnt_pwm, cnt_step, lvl and duty_q SHALL all be 0, every FSM SHALL be in IDLE, led SHALL be all 1s and breath_done SHALL be all 0s.
REQ-025 Reset asserted mid-breath SHALL abort immediately. After release, channels with en high SHALL restart from RISE at lvl 0.

Configuration
REQ-026 Macro BREATH_GAMMA_EN defined: duty SHALL be lvl*lvl*(PWM_PERIOD/(STEPS*STEPS)), and PWM_PERIOD SHALL be divisible by STEPS*STEPS. The default 500_000/400 = 1250 satisfies this.
REQ-027 Macro BREATH_GAMMA_EN undefined: the linear duty of REQ-020 SHALL apply, and no multiplier beyond the constant scale SHALL be inferred.

Verification (bench parameters: CH=2, PWM_PERIOD=64, PWM_W=7, STEPS=4, STEP_CYCLES=2)
REQ-028 Reset release with en=2'b01, first tick at clk 128 -> in the next period, led[0] is low for 16 clks then high for 48; led[1] stays 1 throughout.
REQ-029 en[0] held high for 8 ticks (1024 clks) -> led[0] low-time follows 16, 32, 48, 64, 48, 32, 16, 0; a single breath_done[0] pulse occurs at the 8th tick; the sequence then repeats.
REQ-030 en[0] dropped mid-RISE at lvl 2, coinciding with a tick -> led[0] = 1 on the next clk and lvl stays 0. When re-enabled, low-time restarts at 16 after the next tick.
REQ-031 With BREATH_GAMMA_EN defined, rising levels 1..4 -> led[0] low-time is 4, 16, 36, 64 clks.
REQ-032 rst_n pulsed low for 3 clks at lvl 3 in FALL -> during reset, led = 2'b11 and breath_done = 0. After release, the first tick gives low-time 16.

Source files
------------

// File: rtl/pwm_breath_multi.sv
// Multi-channel breathing-LED PWM: shared period/step timebase, per-channel rise/fall level FSM.
// Define BREATH_GAMMA_EN for a quadratic (gamma-like) level-to-duty curve; linear otherwise.
`timescale 1ns/1ps
module pwm_breath_multi #(
  parameter int CH          = 4,
  parameter int PWM_PERIOD  = 500_000,
  parameter int PWM_W       = 19,
  parameter int STEPS       = 20,
  parameter int STEP_CYCLES = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH-1:0] en,
  output logic [CH-1:0] led,
  output logic [CH-1:0] breath_done
);

  localparam int LVL_W  = $clog2(STEPS + 1);
  localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int PROD_W = PWM_W + 2 * LVL_W;
`ifdef BREATH_GAMMA_EN
  localparam int SCALE  = PWM_PERIOD / (STEPS * STEPS);
`else
  localparam int SCALE  = PWM_PERIOD / STEPS;
`endif

  localparam logic [PWM_W-1:0]  PWM_LAST  = PWM_W'(PWM_PERIOD - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
  localparam logic [LVL_W-1:0]  LVL_TOP   = LVL_W'(STEPS);
  localparam logic [LVL_W-1:0]  LVL_ONE   = LVL_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_RISE, S_FALL} state_t;

  // Level to duty; the scale is a compile-time constant so only the gamma build squares lvl.
  function automatic logic [PWM_W-1:0] f_duty(input logic [LVL_W-1:0] lvl);
`ifdef BREATH_GAMMA_EN
    return PWM_W'(PROD_W'(lvl) * PROD_W'(lvl) * PROD_W'(SCALE));
`else
    return PWM_W'(PROD_W'(lvl) * PROD_W'(SCALE));
`endif
  endfunction

  logic [PWM_W-1:0]  r_cnt_pwm;
  logic [STEP_W-1:0] r_cnt_step;
  logic              w_pwm_wrap;
  logic              w_tick;

  assign w_pwm_wrap = (r_cnt_pwm == PWM_LAST);
  assign w_tick     = w_pwm_wrap && (r_cnt_step == STEP_LAST);

  // Free-running timebase shared by every channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_pwm  <= '0;
      r_cnt_step <= '0;
    end else if (w_pwm_wrap) begin
      r_cnt_pwm  <= '0;
      r_cnt_step <= (r_cnt_step == STEP_LAST) ? '0 : r_cnt_step + STEP_W'(1);
    end else begin
      r_cnt_pwm  <= r_cnt_pwm + PWM_W'(1);
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    state_t           r_state;
    state_t           w_state_nxt;
    logic [LVL_W-1:0] r_lvl;
    logic [LVL_W-1:0] w_lvl_nxt;
    logic [PWM_W-1:0] r_duty;
    logic [PWM_W-1:0] w_duty_nxt;
    logic             r_led;
    logic             r_done;
    logic             w_done_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= S_IDLE;
        r_lvl   <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_lvl   <= w_lvl_nxt;
      end
    end

    // Disable wins over a coincident tick
    always_comb begin
      w_state_nxt = r_state;
      w_lvl_nxt   = r_lvl;
      if (!en[g]) begin
        w_state_nxt = S_IDLE;
        w_lvl_nxt   = '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            w_state_nxt = S_RISE;
            w_lvl_nxt   = '0;
          end
          S_RISE: begin
            if (w_tick) begin
              w_lvl_nxt = r_lvl + LVL_ONE;
              if (r_lvl + LVL_ONE == LVL_TOP) w_state_nxt = S_FALL;
            end
          end
          S_FALL: begin
            if (w_tick) begin
              w_lvl_nxt = r_lvl - LVL_ONE;
              if (r_lvl == LVL_ONE) w_state_nxt = S_RISE;
            end
          end
          default: begin
            w_state_nxt = S_IDLE;
            w_lvl_nxt   = '0;
          end
        endcase
      end
    end

    always_comb begin
      w_done_nxt = en[g] && (r_state == S_FALL) && w_tick && (r_lvl == LVL_ONE);
      w_duty_nxt = f_duty(w_lvl_nxt);
    end

    // Duty only changes at the period boundary so a period never sees two thresholds
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_duty <= '0;
        r_led  <= 1'b1;
        r_done <= 1'b0;
      end else begin
        r_led  <= ~(en[g] && (r_cnt_pwm < r_duty));
        r_done <= w_done_nxt;
        if (w_pwm_wrap) r_duty <= w_duty_nxt;
      end
    end

    assign led[g]         = r_led;
    assign breath_done[g] = r_done;
  end

endmodule

// File: tb/tb_pwm_breath_multi.sv
// Bench for pwm_breath_multi: breath position modelled as ticks-since-enable on a triangle wave.
`timescale 1ns/1ps
module tb_pwm_breath_multi;
  localparam int CH = 2, P = 64, PW = 7, S = 4, SC = 2, TP = P * SC;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] en = '0;
  logic [CH-1:0] led;
  logic [CH-1:0] breath_done;

  int n_run = 0;
  int n_fail = 0;

  int            m_t;
  int            m_k[CH];
  int            m_duty[CH];
  logic [CH-1:0] m_led;
  logic [CH-1:0] m_done;
`ifdef BREATH_GAMMA_EN
  int seq[8] = '{4, 16, 36, 64, 36, 16, 4, 0};
`else
  int seq[8] = '{16, 32, 48, 64, 48, 32, 16, 0};
`endif

  pwm_breath_multi #(.CH(CH), .PWM_PERIOD(P), .PWM_W(PW), .STEPS(S), .STEP_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .led(led), .breath_done(breath_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int tri_lvl(int k);
    int p;
    p = k % (2 * S);
    return (p <= S) ? p : 2 * S - p;
  endfunction

  function automatic int exp_duty(int lvl);
`ifdef BREATH_GAMMA_EN
    return lvl * lvl * P / (S * S);
`else
    return lvl * P / S;
`endif
  endfunction

  task automatic model_reset();
    m_t = 0;
    for (int i = 0; i < CH; i++) begin
      m_k[i] = -1;
      m_duty[i] = 0;
    end
    m_led = '1;
    m_done = '0;
  endtask

  // m_k < 0: disabled; otherwise number of ticks seen since the channel was enabled
  task automatic model_step();
    bit wrap, tick;
    wrap = (m_t % P) == P - 1;
    tick = (m_t % TP) == TP - 1;
    for (int i = 0; i < CH; i++) begin
      m_led[i] = !(en[i] && (m_t % P) < m_duty[i]);
      m_done[i] = 1'b0;
      if (!en[i]) m_k[i] = -1;
      else if (m_k[i] < 0) m_k[i] = 0;
      else if (tick) begin
        m_k[i]++;
        m_done[i] = (m_k[i] % (2 * S)) == 0;
      end
      if (wrap) m_duty[i] = exp_duty(m_k[i] < 0 ? 0 : tri_lvl(m_k[i]));
    end
    m_t++;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 2'b11;
    model_reset();
    repeat (3) begin
      cyc();
      n_run++;
      if (led !== 2'b11) begin n_fail++; $display("FAIL reset_led got %b want 11", led); end
      n_run++;
      if (breath_done !== 2'b00) begin n_fail++; $display("FAIL reset_done got %b want 00", breath_done); end
    end
    en = 2'b01;
    rst_n = 1'b1;
  endtask

  task automatic test_first_tick();
    int low, low1;
    for (int c = 0; c < TP; c++) begin
      cyc();
      n_run++;
      if (led !== m_led || breath_done !== m_done) begin
        n_fail++;
        $display("FAIL first_tick t=%0d led got %b want %b done got %b want %b", m_t, led, m_led, breath_done, m_done);
      end
    end
    low = 0;
    low1 = 0;
    for (int c = 0; c < 2 * P; c++) begin
      cyc();
      if (c < P && !led[0]) low++;
      if (!led[1]) low1++;
      n_run++;
      if (led !== m_led || breath_done !== m_done) begin
        n_fail++;
        $display("FAIL first_tick t=%0d led got %b want %b done got %b want %b", m_t, led, m_led, breath_done, m_done);
      end
    end
    n_run++;
    if (low != seq[0]) begin n_fail++; $display("FAIL first_low got %0d want %0d", low, seq[0]); end
    n_run++;
    if (low1 != 0) begin n_fail++; $display("FAIL ch1_idle low-time got %0d want 0", low1); end
  endtask

  task automatic test_breath();
    int low, done_n, done_t;
    done_n = 0;
    done_t = -1;
    for (int j = 2; j <= 9; j++) begin
      low = 0;
      for (int c = 0; c < TP; c++) begin
        cyc();
        if (c < P && !led[0]) low++;
        if (breath_done[0] === 1'b1) begin done_n++; done_t = m_t; end
        n_run++;
        if (led !== m_led || breath_done !== m_done) begin
          n_fail++;
          $display("FAIL breath t=%0d led got %b want %b done got %b want %b", m_t, led, m_led, breath_done, m_done);
        end
      end
      n_run++;
      if (low != seq[(j - 1) % 8]) begin
        n_fail++;
        $display("FAIL breath_low tick%0d got %0d want %0d", j, low, seq[(j - 1) % 8]);
      end
    end
    n_run++;
    if (done_n != 1) begin n_fail++; $display("FAIL done_count got %0d want 1", done_n); end
    n_run++;
    if (done_t != 8 * TP) begin n_fail++; $display("FAIL done_time got %0d want %0d", done_t, 8 * TP); end
  endtask

  task automatic test_disable_mid();
    int low, guard;
    for (int c = 0; c < TP - 1; c++) begin
      cyc();
      n_run++;
      if (led !== m_led || breath_done !== m_done) begin
        n_fail++;
        $display("FAIL disable t=%0d led got %b want %b done got %b want %b", m_t, led, m_led, breath_done, m_done);
      end
    end
    en[0] = 1'b0;
    cyc();
    n_run++;
    if (led[0] !== 1'b1) begin n_fail++; $display("FAIL disable_led got %b want 1", led[0]); end
    low = 0;
    for (int c = 0; c < 200; c++) begin
      cyc();
      if (!led[0]) low++;
      n_run++;
      if (led !== m_led || breath_done !== m_done) begin
        n_fail++;
        $display("FAIL disable t=%0d led got %b want %b done got %b want %b", m_t, led, m_led, breath_done, m_done);
      end
    end
    n_run++;
    if (low != 0) begin n_fail++; $display("FAIL disabled_low got %0d want 0", low); end
    en[0] = 1'b1;
    guard = 0;
    while ((m_t % TP) != 0 && guard < 2 * TP) begin
      cyc();
      guard++;
      n_run++;
      if (led !== m_led || breath_done !== m_done) begin
        n_fail++;
        $display("FAIL reenable t=%0d led got %b want %b done got %b want %b", m_t, led, m_led, breath_done, m_done);
      end
    end
    low = 0;
    for (int c = 0; c < P; c++) begin
      cyc();
      if (!led[0]) low++;
    end
    n_run++;
    if (low != seq[0]) begin n_fail++; $display("FAIL reenable_low got %0d want %0d", low, seq[0]); end
  endtask

  task automatic test_reset_mid();
    int low;
    while (m_t < 5 * TP + 1664 - TP + 10) begin
      cyc();
      n_run++;
      if (led !== m_led || breath_done !== m_done) begin
        n_fail++;
        $display("FAIL pre_reset t=%0d led got %b want %b done got %b want %b", m_t, led, m_led, breath_done, m_done);
      end
    end
    rst_n = 1'b0;
    #1;
    n_run++;
    if (led !== 2'b11) begin n_fail++; $display("FAIL async_reset_led got %b want 11", led); end
    model_reset();
    repeat (3) begin
      cyc();
      n_run++;
      if (led !== 2'b11 || breath_done !== 2'b00) begin
        n_fail++;
        $display("FAIL mid_reset led got %b want 11 done got %b want 00", led, breath_done);
      end
    end
    rst_n = 1'b1;
    for (int c = 0; c < TP; c++) begin
      cyc();
      n_run++;
      if (led !== m_led || breath_done !== m_done) begin
        n_fail++;
        $display("FAIL post_reset t=%0d led got %b want %b done got %b want %b", m_t, led, m_led, breath_done, m_done);
      end
    end
    low = 0;
    for (int c = 0; c < P; c++) begin
      cyc();
      if (!led[0]) low++;
    end
    n_run++;
    if (low != seq[0]) begin n_fail++; $display("FAIL post_reset_low got %0d want %0d", low, seq[0]); end
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 299) == 0) en = CH'($urandom);
      if (hold > 0) begin
        hold--;
        if (hold == 0) rst_n = 1'b1;
      end else if ($urandom_range(0, 1499) == 0) begin
        rst_n = 1'b0;
        hold = $urandom_range(1, 4);
      end
      cyc();
      n_run++;
      if (led !== m_led || breath_done !== m_done) begin
        n_fail++;
        $display("FAIL random t=%0d en=%b led got %b want %b done got %b want %b", m_t, en, led, m_led, breath_done, m_done);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_tick();
    test_breath();
    test_disable_mid();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
